// File: rtl/serial_load_pkg.sv
// Shared FSM encoding and helpers for the serial word loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_load_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Shift one bit into a word of 'width' bits, held zero-extended in 16 bits.
    // MSB-first enters at bit 0 and moves up; LSB-first enters at the top and moves down.
    function automatic logic [15:0] shift_in(input logic [15:0] q, input logic b,
                                             input int width, input logic msb_first);
        logic [15:0] r;
        if (msb_first) begin
            r = {q[14:0], b};
        end else begin
            r = q >> 1;
            r[4'(width - 1)] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register; clear with shift loads a fresh first bit.
// Latency: 1 cycle from shift_en to q.
// Backpressure: none, shifts whenever shift_en is high.
import serial_load_pkg::*;

module sipo_shift_reg #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [15:0] base;

    always_comb begin
        base = clear ? 16'd0 : 16'(q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (shift_en) begin
            q <= WIDTH'(shift_in(base, sin, WIDTH, MSB_FIRST != 0));
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Framed serial receiver with optional even parity, emitting a word and a one-cycle load pulse.
// Latency: en_out/parity_err one cycle after the final accepted bit.
// Backpressure: none; sin_valid gaps simply stall the frame, no timeout.
import serial_load_pkg::*;

module serial_load_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             busy,
    output logic             parity_err
);

    localparam int CNT_W = clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             par;
    logic             par_next;
    logic             data_bit;
    logic             parity_bit;
    logic             last_bit;
    logic             restart;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word_next;

    // sof with a valid bit restarts the frame from any state, including PARITY.
    always_comb begin
        restart    = sin_valid && sof;
        data_bit   = sin_valid && (sof || state == ST_SHIFT);
        parity_bit = sin_valid && !sof && state == ST_PARITY;
        cnt_next   = sof ? CNT_W'(1) : cnt + CNT_W'(1);
        par_next   = sof ? sin : par ^ sin;
        last_bit   = data_bit && cnt_next == CNT_W'(WIDTH);
        word_next  = WIDTH'(shift_in(sof ? 16'd0 : 16'(q), sin, WIDTH, MSB_FIRST != 0));
    end

    sipo_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sipo (
        .clk     (clk),
        .reset   (reset),
        .shift_en(data_bit),
        .clear   (restart),
        .sin     (sin),
        .q       (q)
    );

    assign busy = state != ST_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            par        <= 1'b0;
            d_out      <= '0;
            en_out     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            en_out     <= 1'b0;
            parity_err <= 1'b0;
            if (data_bit) begin
                par <= par_next;
                // Without parity the last data bit loads straight from the bypassed word.
                if (last_bit && PARITY_EN == 0) begin
                    d_out  <= word_next;
                    en_out <= 1'b1;
                    state  <= ST_IDLE;
                    cnt    <= '0;
                end else begin
                    state <= last_bit ? ST_PARITY : ST_SHIFT;
                    cnt   <= cnt_next;
                end
            end else if (parity_bit) begin
                state <= ST_IDLE;
                cnt   <= '0;
                if (par ^ sin) begin
                    parity_err <= 1'b1;
                end else begin
                    d_out  <= q;
                    en_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: three configurations driven in lockstep, checked against a frame-level model.
module tb_serial_load_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sin = 1'b0;
    logic sin_valid = 1'b0;
    logic sof = 1'b0;

    logic [W-1:0] dq [3];
    logic enq [3];
    logic busyq [3];
    logic peq [3];

    always #5 clk = ~clk;

    // dut 0: MSB first with parity; dut 1: LSB first with parity; dut 2: MSB first, no parity
    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1), .PARITY_EN(1)) u0 (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .d_out(dq[0]), .en_out(enq[0]), .busy(busyq[0]), .parity_err(peq[0]));
    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(0), .PARITY_EN(1)) u1 (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .d_out(dq[1]), .en_out(enq[1]), .busy(busyq[1]), .parity_err(peq[1]));
    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1), .PARITY_EN(0)) u2 (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .d_out(dq[2]), .en_out(enq[2]), .busy(busyq[2]), .parity_err(peq[2]));

    int cfg_msb [3] = '{1, 0, 1};
    int cfg_pe  [3] = '{1, 1, 0};

    // Reference model: list of received data bits per frame, plus a waiting-for-parity flag.
    int       mn    [3];
    bit       mwait [3];
    bit       mb    [3][16];
    logic [W-1:0] xd [3];
    logic     xen   [3];
    logic     xpe   [3];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, c, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] assemble(input int c);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (cfg_msb[c] != 0) w[W-1-i] = mb[c][i];
            else                 w[i]     = mb[c][i];
        end
        return w;
    endfunction

    task automatic data_done(input int c);
        if (cfg_pe[c] != 0) begin
            mwait[c] = 1'b1;
        end else begin
            xd[c]  = assemble(c);
            xen[c] = 1'b1;
            mn[c]  = 0;
        end
    endtask

    task automatic model_edge(input int c, input logic r, input logic v, input logic sf, input logic b);
        int ones;
        xen[c] = 1'b0;
        xpe[c] = 1'b0;
        if (r) begin
            mn[c] = 0; mwait[c] = 1'b0; xd[c] = '0;
        end else if (v) begin
            if (sf) begin
                mn[c] = 1; mb[c][0] = b; mwait[c] = 1'b0;
                if (W == 1) data_done(c);
            end else if (mwait[c]) begin
                ones = int'(b);
                for (int i = 0; i < W; i++) ones += int'(mb[c][i]);
                if (ones % 2 == 0) begin
                    xd[c] = assemble(c); xen[c] = 1'b1;
                end else begin
                    xpe[c] = 1'b1;
                end
                mn[c] = 0; mwait[c] = 1'b0;
            end else if (mn[c] > 0) begin
                mb[c][mn[c]] = b;
                mn[c]++;
                if (mn[c] == W) data_done(c);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic sf, input logic b);
        reset = r; sin_valid = v; sof = sf; sin = b;
        @(posedge clk);
        for (int c = 0; c < 3; c++) model_edge(c, r, v, sf, b);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("d_out", c, 16'(dq[c]), 16'(xd[c]));
            chk("en_out", c, 16'(enq[c]), 16'(xen[c]));
            chk("parity_err", c, 16'(peq[c]), 16'(xpe[c]));
            chk("busy", c, 16'(busyq[c]), 16'(mn[c] > 0 || mwait[c]));
        end
    endtask

    task automatic frame(input logic [W-1:0] bits_msb_order, input logic p, input bit with_p);
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, i == W - 1, bits_msb_order[i]);
        if (with_p) step(1'b0, 1'b1, 1'b0, p);
    endtask

    typedef struct {
        logic r, v, sf, b;
        logic [W-1:0] d;
        logic en, busy, pe;
    } vec_t;

    vec_t tbl [16];
    logic [W-1:0] seen [4];
    int pulses;

    initial begin
        for (int c = 0; c < 3; c++) begin
            mn[c] = 0; mwait[c] = 1'b0; xd[c] = '0; xen[c] = 1'b0; xpe[c] = 1'b0;
        end

        // reset mid-frame, clean 1011 p=1, then 0110 p=1 parity error (expectations for dut 0)
        tbl[0]  = '{1,0,0,0, 4'b0000, 0,0,0};
        tbl[1]  = '{0,1,1,1, 4'b0000, 0,1,0};
        tbl[2]  = '{0,1,0,0, 4'b0000, 0,1,0};
        tbl[3]  = '{1,0,0,0, 4'b0000, 0,0,0};
        tbl[4]  = '{0,1,1,1, 4'b0000, 0,1,0};
        tbl[5]  = '{0,1,0,0, 4'b0000, 0,1,0};
        tbl[6]  = '{0,1,0,1, 4'b0000, 0,1,0};
        tbl[7]  = '{0,1,0,1, 4'b0000, 0,1,0};
        tbl[8]  = '{0,1,0,1, 4'b1011, 1,0,0};
        tbl[9]  = '{0,0,0,0, 4'b1011, 0,0,0};
        tbl[10] = '{0,1,1,0, 4'b1011, 0,1,0};
        tbl[11] = '{0,1,0,1, 4'b1011, 0,1,0};
        tbl[12] = '{0,1,0,1, 4'b1011, 0,1,0};
        tbl[13] = '{0,1,0,0, 4'b1011, 0,1,0};
        tbl[14] = '{0,1,0,1, 4'b1011, 0,0,1};
        tbl[15] = '{0,0,0,0, 4'b1011, 0,0,0};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].sf, tbl[i].b);
            chk("tbl_d", 0, 16'(dq[0]), 16'(tbl[i].d));
            chk("tbl_en", 0, 16'(enq[0]), 16'(tbl[i].en));
            chk("tbl_busy", 0, 16'(busyq[0]), 16'(tbl[i].busy));
            chk("tbl_perr", 0, 16'(peq[0]), 16'(tbl[i].pe));
        end

        // gapped LSB-first frame 1,1,0,0 with parity 0 on dut 1
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k < W; k++) begin
            repeat (3) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                chk("gap_busy", 1, 16'(busyq[1]), 16'd1);
            end
            step(1'b0, 1'b1, 1'b0, k == 1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_d", 1, 16'(dq[1]), 16'h3);
        chk("gap_en", 1, 16'(enq[1]), 16'd1);

        // abort after 3 bits, then back-to-back A and 5 on dut 0
        pulses = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int i = W - 1; i >= 0; i--) begin
                step(1'b0, 1'b1, i == W - 1, (f == 0) ? ((4'hA >> i) & 1) != 0 : ((4'h5 >> i) & 1) != 0);
                if (enq[0]) begin seen[pulses % 4] = dq[0]; pulses++; end
            end
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (enq[0]) begin seen[pulses % 4] = dq[0]; pulses++; end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (enq[0]) begin seen[pulses % 4] = dq[0]; pulses++; end
        chk("b2b_pulses", 0, 16'(pulses), 16'd2);
        chk("b2b_first", 0, 16'(seen[0]), 16'hA);
        chk("b2b_second", 0, 16'(seen[1]), 16'h5);

        // stray bits in IDLE, then 1111 (dut 2 loads after the 4th bit, no parity)
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            chk("stray_busy", 2, 16'(busyq[2]), 16'd0);
        end
        frame(4'hF, 1'b0, 1'b0);
        chk("nopar_d", 2, 16'(dq[2]), 16'hF);
        chk("nopar_en", 2, 16'(enq[2]), 16'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_load_ctrl.md
Name: serial_load_ctrl

Overview:
Upstream feeder for the 4-bit enabled storage register. It collects a framed serial bit stream, checks optional even parity and emits a parallel word with a one-cycle load-enable pulse. Its d_out and en_out connect directly to the register's d and en. Its clk drives the register and the stage that follows.

Parameters:
WIDTH, 4, number of data bits per frame and width of d_out (legal range 1..16)
MSB_FIRST, 1, 1 = first received bit lands in d_out[WIDTH-1]; 0 = first bit lands in d_out[0]
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset
sin  input  1  serial data bit, sampled only when sin_valid=1
sin_valid  input  1  sin carries a bit this cycle
sof  input  1  start-of-frame; qualified by sin_valid; marks the first data bit
d_out  output  WIDTH  last successfully received word; drives register d
en_out  output  1  one-cycle load pulse; drives register en
busy  output  1  high while a frame is in progress (state != IDLE)
parity_err  output  1  one-cycle pulse when a parity check fails

Interface decision (already decided): one clock; reset is synchronous and active-high. Ports are named clk and reset.

Behaviour:
- Reset (sampled on a clk edge with reset=1): d_out=0, en_out=0, busy=0, parity_err=0, state=IDLE, bit count=0, shift register=0. Reset overrides all other inputs, including mid-frame; a partial frame is discarded.
- All outputs are registered. busy is derived from the state register.
- States: IDLE, SHIFT, PARITY.
- IDLE:
  - sin_valid=1 and sof=1: accept sin as bit 0, count=1.
  - Then go to SHIFT, or if WIDTH=1 take the end-of-data path.
  - sin_valid=1 with sof=0 is ignored (stray bits dropped).
- SHIFT:
  - Each sin_valid=1 shifts sin in and increments count. Direction is set by MSB_FIRST.
  - sin_valid=0 holds state; there is no timeout.
  - sof=1 with sin_valid=1 aborts the current frame and restarts with this bit as bit 0 (count=1). No pulse is emitted for the aborted frame.
- End of data (count reaches WIDTH on an accepted bit):
  - PARITY_EN=0: the next cycle has d_out=assembled word and en_out=1; state returns to IDLE.
  - PARITY_EN=1: go to PARITY.
- PARITY:
  - The next accepted bit is the parity bit.
  - If XOR(data bits, parity bit)=0: next cycle d_out=word, en_out=1, state IDLE.
  - Otherwise: next cycle parity_err=1, en_out=0, d_out unchanged, state IDLE.
  - sof=1 with sin_valid=1 in PARITY counts as an abort plus restart (treated as a new bit 0), not as the parity bit.
- Latency: en_out and parity_err rise exactly one cycle after the edge that accepts the final bit (last data bit, or the parity bit). Both are high for exactly one cycle.
- Back-to-back frames: sof is accepted in the same cycle en_out is high. No dead cycle is required between frames.
- d_out changes only on a successful load (or reset) and holds its value otherwise.
- The bit counter is ceil(log2(WIDTH+1)) bits wide. It resets to 0 on every return to IDLE, so there is no wrap-around.

Decomposition:
- Shared package serial_load_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2
  - counter-width function clog2
- One sub-module, sipo_shift_reg:
  - parameters WIDTH, MSB_FIRST
  - ports clk, reset, shift_en, clear, sin, q
- FSM, counter and parity accumulator stay in the top module. Parity is a running XOR cleared at bit 0.

Test Plan:
- Reset mid-frame: reset after 2 of 4 bits, then a clean frame 1,0,1,1 with parity 1 (MSB_FIRST=1) -> no pulse before reset; one cycle after the parity bit, d_out=4'b1011, en_out=1 for one cycle; busy low afterwards.
- Parity error: frame 0,1,1,0 with parity 1 -> parity_err=1 for one cycle, en_out stays 0, d_out keeps its previous value 4'b1011.
- Gapped input and LSB order: MSB_FIRST=0, bits 1,1,0,0 with sin_valid dropped for 3 cycles between bits, parity 0 -> d_out=4'b0011, en_out pulse, busy high throughout the gaps.
- Abort and back-to-back: a new sof after 3 bits aborts the frame; then two consecutive frames 4'hA and 4'h5, the second sof in the same cycle as the first en_out -> exactly two en_out pulses, with d_out=4'hA then 4'h5.
- Stray bits and no parity: PARITY_EN=0, sin_valid=1 bits with sof=0 in IDLE, then a frame 1,1,1,1 -> stray bits ignored, busy stays low during them; d_out=4'hF one cycle after the 4th bit.
